seg7_scan_driver: RTL and testbench



---
 rtl/seg7_scan_driver.sv | 133 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed multi-digit 7-segment driver: shadowed BCD value, programmable
// scan rate, per-digit decimal point, leading-zero suppression and global blanking.
module seg7_scan_driver #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned DIV    = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  lz_en,
  input  logic                  blank,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                wrap_q, wrap_d;
  logic [4*DIGITS-1:0] shadow_bcd_q, shadow_bcd_d;
  logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                frame_q, frame_d;

  logic                advance;
  logic [3:0]          nib;
  logic                dp_sel;
  logic                sup_sel;
  logic                all_zero;

  // BCD nibble to {a,b,c,d,e,f,g}; non-decimal codes render dark
  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  always_comb begin
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    wrap_d       = 1'b0;
    shadow_bcd_d = shadow_bcd_q;
    shadow_dp_d  = shadow_dp_q;
    seg_d        = 7'b0000000;
    dp_d         = 1'b0;
    an_d         = '0;
    frame_d      = wrap_q;
    nib          = 4'd0;
    dp_sel       = 1'b0;
    sup_sel      = 1'b0;
    all_zero     = 1'b1;

    advance = (cnt_q == CNT_MAX);
    cnt_d   = advance ? '0 : cnt_q + CNT_W'(1);
    if (advance) begin
      idx_d  = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
      wrap_d = (idx_q == IDX_MAX);
    end

    if (load) begin
      shadow_bcd_d = bcd_in;
      shadow_dp_d  = dp_in;
    end

    // Walk from the top digit down so all_zero covers nibbles k..DIGITS-1
    for (int k = DIGITS - 1; k >= 0; k--) begin
      all_zero = all_zero && (shadow_bcd_q[4*k +: 4] == 4'd0);
      if (idx_q == IDX_W'(k)) begin
        nib     = shadow_bcd_q[4*k +: 4];
        dp_sel  = shadow_dp_q[k];
        sup_sel = lz_en && all_zero && (k != 0);
      end
    end

    if (!blank) begin
      seg_d = sup_sel ? 7'b0000000 : decode(nib);
      dp_d  = dp_sel;
      an_d  = DIGITS'(1) << idx_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      wrap_q       <= 1'b0;
      shadow_bcd_q <= '0;
      shadow_dp_q  <= '0;
      seg_q        <= 7'b0000000;
      dp_q         <= 1'b0;
      an_q         <= '0;
      frame_q      <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      wrap_q       <= wrap_d;
      shadow_bcd_q <= shadow_bcd_d;
      shadow_dp_q  <= shadow_dp_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_q      <= frame_d;
    end
  end

  assign seg   = seg_q;
  assign dp    = dp_q;
  assign an    = an_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a 4-digit/DIV=4 instance and a
// 3-digit/DIV=1 instance, expected per-cycle outputs queued ahead of time.
module tb_seg7_scan_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: DIGITS=4, DIV=4
  logic        rst_a_n, load_a, lz_a, blank_a;
  logic [15:0] bcd_a;
  logic [3:0]  dpi_a;
  logic [6:0]  seg_a;
  logic        dp_a, frame_a;
  logic [3:0]  an_a;

  // Instance B: DIGITS=3, DIV=1
  logic        rst_b_n, load_b, lz_b, blank_b;
  logic [11:0] bcd_b;
  logic [2:0]  dpi_b;
  logic [6:0]  seg_b;
  logic        dp_b, frame_b;
  logic [2:0]  an_b;

  seg7_scan_driver #(.DIGITS(4), .DIV(4)) u_a (
    .clk(clk), .rst_n(rst_a_n), .load(load_a), .bcd_in(bcd_a), .dp_in(dpi_a),
    .lz_en(lz_a), .blank(blank_a), .seg(seg_a), .dp(dp_a), .an(an_a), .frame(frame_a)
  );

  seg7_scan_driver #(.DIGITS(3), .DIV(1)) u_b (
    .clk(clk), .rst_n(rst_b_n), .load(load_b), .bcd_in(bcd_b), .dp_in(dpi_b),
    .lz_en(lz_b), .blank(blank_b), .seg(seg_b), .dp(dp_b), .an(an_b), .frame(frame_b)
  );

  typedef struct {
    int         cyc;
    bit         which;
    logic [6:0] seg;
    logic       dp;
    logic [7:0] an;
    logic       frame;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  logic [6:0] tseg [0:3];
  logic       tdp  [0:3];

  // segs packs {d3,d2,d1,d0}, dps packs {d3,d2,d1,d0}
  task automatic set_tab(input logic [27:0] segs, input logic [3:0] dps);
    for (int k = 0; k < 4; k++) begin
      tseg[k] = segs[7*k +: 7];
      tdp[k]  = dps[k];
    end
  endtask

  task automatic push_zero(input int c, input bit which);
    exp_t e;
    e.cyc = c; e.which = which; e.seg = 7'b0; e.dp = 1'b0; e.an = 8'b0; e.frame = 1'b0;
    sb.push_back(e);
  endtask

  // Expected outputs of instance A for cycles c0..c1; r is the first edge after reset release
  task automatic push_a(input int c0, input int c1, input int r, input bit dark);
    exp_t e;
    int d;
    for (int c = c0; c <= c1; c++) begin
      d = ((c - r) / 4) % 4;
      e.cyc = c; e.which = 1'b0;
      if (dark) begin
        e.seg = 7'b0; e.dp = 1'b0; e.an = 8'b0; e.frame = 1'b0;
      end else begin
        e.seg = tseg[d]; e.dp = tdp[d]; e.an = 8'(1 << d);
        e.frame = ((c - r) % 16 == 0) && (c > r);
      end
      sb.push_back(e);
    end
  endtask

  task automatic push_b(input int c0, input int c1, input int r);
    exp_t e;
    int d;
    for (int c = c0; c <= c1; c++) begin
      d = (c - r) % 3;
      e.cyc = c; e.which = 1'b1;
      e.seg = tseg[d]; e.dp = tdp[d]; e.an = 8'(1 << d);
      e.frame = ((c - r) % 3 == 0) && (c > r);
      sb.push_back(e);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every cycle with a queued expectation is compared at the falling edge
  always @(negedge clk) begin : monitor
    exp_t e;
    logic [15:0] act, req;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.cyc != cyc) begin
        failures++;
        $display("FAIL stale_entry cyc=%0d expected_at=%0d", cyc, e.cyc);
      end else begin
        if (e.which)
          act = {seg_b, dp_b, 5'b0, an_b, frame_b};
        else
          act = {seg_a, dp_a, 4'b0, an_a, frame_a};
        req = {e.seg, e.dp, e.an, e.frame};
        if (act !== req) begin
          failures++;
          $display("FAIL %s cyc=%0d actual seg=%b dp=%b an=%b frame=%b required seg=%b dp=%b an=%b frame=%b",
                   e.which ? "dutB" : "dutA", cyc, act[15:9], act[8], act[7:1], act[0],
                   req[15:9], req[8], req[7:1], req[0]);
        end
      end
    end
  end

  initial begin
    rst_a_n = 1'b0; load_a = 1'b1; bcd_a = 16'h9999; dpi_a = 4'hF; lz_a = 1'b0; blank_a = 1'b0;
    rst_b_n = 1'b0; load_b = 1'b0; bcd_b = 12'h000; dpi_b = 3'b0;  lz_b = 1'b0; blank_b = 1'b0;

    // Reset with load held high: outputs dark, shadow stays zero
    for (int c = 1; c <= 3; c++) push_zero(c, 1'b0);
    set_tab({7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110}, 4'b0000);
    push_a(4, 5, 4, 1'b0);
    wait_until(3);
    rst_a_n = 1'b1; load_a = 1'b0;

    // Load 1234 with dp on digit 2; visible two cycles after load
    wait_until(4);
    load_a = 1'b1; bcd_a = 16'h1234; dpi_a = 4'b0100;
    set_tab({7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011}, 4'b0100);
    push_a(6, 35, 4, 1'b0);
    wait_until(5);
    load_a = 1'b0;

    // Load 0040 with leading-zero suppression; suppressed digit 3 keeps its dp
    wait_until(34);
    load_a = 1'b1; bcd_a = 16'h0040; dpi_a = 4'b1000;
    set_tab({7'b0000000, 7'b0000000, 7'b0110011, 7'b1111110}, 4'b1000);
    push_a(36, 51, 4, 1'b0);
    wait_until(35);
    load_a = 1'b0; lz_a = 1'b1;

    // Suppression off: upper zeros reappear
    wait_until(51);
    lz_a = 1'b0;
    set_tab({7'b1111110, 7'b1111110, 7'b0110011, 7'b1111110}, 4'b1000);
    push_a(52, 67, 4, 1'b0);

    // Invalid nibble A on digit 1, then a blank window mid-scan
    wait_until(66);
    load_a = 1'b1; bcd_a = 16'h00A5; dpi_a = 4'b0000;
    set_tab({7'b1111110, 7'b1111110, 7'b0000000, 7'b1011011}, 4'b0000);
    push_a(68, 86, 4, 1'b0);
    push_a(87, 96, 4, 1'b1);
    push_a(97, 108, 4, 1'b0);
    wait_until(67);
    load_a = 1'b0;
    wait_until(86);
    blank_a = 1'b1;
    wait_until(96);
    blank_a = 1'b0;

    // Reset while idx=2, cnt=1: dark next cycle, then full digit-0 slot
    wait_until(108);
    rst_a_n = 1'b0;
    push_zero(109, 1'b0);
    wait_until(109);
    rst_a_n = 1'b1;
    set_tab({7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110}, 4'b0000);
    push_a(110, 117, 110, 1'b0);

    // Instance B: advance every cycle, frame every third, load on wrap cycle
    wait_until(120);
    rst_b_n = 1'b1;
    push_b(121, 126, 121);
    wait_until(125);
    load_b = 1'b1; bcd_b = 12'h789; dpi_b = 3'b000;
    set_tab({7'b0000000, 7'b1110000, 7'b1111111, 7'b1111011}, 4'b0000);
    push_b(127, 132, 121);
    wait_until(126);
    load_b = 1'b0;

    wait_until(140);
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain pending=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
